// File: rtl/input_status_framer_pkg.sv
// +--------------------------------------------------------------------------+
// | input_status_framer_pkg : shared FSM encoding and frame header constants |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package input_status_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DAT  = 2'd2
  } state_t;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam int         SEQ_W     = 8;

  function automatic logic [15:0] hdr_word(input logic [SEQ_W-1:0] seq);
    return {HDR_MAGIC, seq};
  endfunction

endpackage

`default_nettype wire

// File: rtl/input_debounce.sv
// +--------------------------------------------------------------------------+
// | input_debounce : one-channel synchroniser, debouncer and edge pulses     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module input_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);

  localparam int             CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  c_cnt_max = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // New level is accepted in the cycle the counter reaches its limit; the
  // edge pulse is registered alongside so both appear together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= {SYNC_STAGES{RESET_VAL}};
      r_cnt    <= '0;
      r_stable <= RESET_VAL;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_sync != r_stable) begin
        if (r_cnt == c_cnt_max) begin
          r_stable <= w_sync;
          r_cnt    <= '0;
          r_rise   <= w_sync;
          r_fall   <= ~w_sync;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;

endmodule

`default_nettype wire

// File: rtl/input_status_framer.sv
// +--------------------------------------------------------------------------+
// | input_status_framer : debounced input status word and LocalLink framer   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module input_status_framer
  import input_status_framer_pkg::*;
#(
  parameter int              N_CH             = 8,
  parameter int              DATA_W           = 16,
  parameter int              SYNC_STAGES      = 2,
  parameter int              DEBOUNCE_CYCLES  = 50000,
  parameter int              HEARTBEAT_CYCLES = 0,
  parameter logic [N_CH-1:0] RESET_STATE      = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   i_in_raw,
  input  logic              i_channel_up,
  output logic [N_CH-1:0]   o_state,
  output logic [N_CH-1:0]   o_rise,
  output logic [N_CH-1:0]   o_fall,
  output logic [DATA_W-1:0] o_tx_d,
  output logic              o_tx_rem,
  output logic              o_tx_src_rdy_n,
  output logic              o_tx_sof_n,
  output logic              o_tx_eof_n,
  input  logic              i_tx_dst_rdy_n,
  output logic [SEQ_W-1:0]  o_seq
);

  logic [N_CH-1:0]   w_state;
  logic [N_CH-1:0]   w_rise;
  logic [N_CH-1:0]   w_fall;
  logic              w_event;
  logic              w_hb_due;
  logic              w_trigger;
  logic              w_accept;
  logic              w_frame_start;

  state_t            r_state;
  logic [N_CH-1:0]   r_snap;
  logic              r_pending;
  logic [SEQ_W-1:0]  r_seq;
  logic [DATA_W-1:0] r_tx_d;
  logic              r_tx_rem;
  logic              r_tx_src_rdy_n;
  logic              r_tx_sof_n;
  logic              r_tx_eof_n;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    input_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (RESET_STATE[i])
    ) u_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_raw    (i_in_raw[i]),
      .o_stable (w_state[i]),
      .o_rise   (w_rise[i]),
      .o_fall   (w_fall[i])
    );
  end

  assign w_event       = |(w_rise | w_fall);
  assign w_trigger     = w_event | r_pending | w_hb_due;
  assign w_accept      = ~r_tx_src_rdy_n & ~i_tx_dst_rdy_n;
  assign w_frame_start = (r_state == ST_IDLE) & w_trigger & i_channel_up;

  if (HEARTBEAT_CYCLES != 0) begin : g_hb
    localparam int            HW       = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
    localparam logic [HW-1:0] c_hb_max = HW'(HEARTBEAT_CYCLES - 1);

    logic [HW-1:0] r_hb_cnt;
    logic          r_hb_due;

    // Any frame start satisfies the heartbeat, so the interval restarts there.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hb_cnt <= '0;
        r_hb_due <= 1'b0;
      end else if (w_frame_start) begin
        r_hb_cnt <= '0;
        r_hb_due <= 1'b0;
      end else if (r_hb_cnt == c_hb_max) begin
        r_hb_cnt <= '0;
        r_hb_due <= 1'b1;
      end else begin
        r_hb_cnt <= r_hb_cnt + 1'b1;
      end
    end

    assign w_hb_due = r_hb_due;
  end else begin : g_no_hb
    assign w_hb_due = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_snap         <= '0;
      r_pending      <= 1'b0;
      r_seq          <= '0;
      r_tx_d         <= '0;
      r_tx_rem       <= 1'b0;
      r_tx_src_rdy_n <= 1'b1;
      r_tx_sof_n     <= 1'b1;
      r_tx_eof_n     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_frame_start) begin
            r_state        <= ST_HDR;
            r_snap         <= w_state;
            r_pending      <= 1'b0;
            r_tx_d         <= hdr_word(r_seq);
            r_tx_rem       <= 1'b1;
            r_tx_src_rdy_n <= 1'b0;
            r_tx_sof_n     <= 1'b0;
            r_tx_eof_n     <= 1'b1;
          end else if (w_trigger) begin
            r_pending <= 1'b1;
          end
        end
        ST_HDR, ST_DAT: begin
          if (!i_channel_up) begin
            // Lost link: drop the frame and resend it with the same sequence.
            r_state        <= ST_IDLE;
            r_pending      <= 1'b1;
            r_tx_d         <= '0;
            r_tx_rem       <= 1'b0;
            r_tx_src_rdy_n <= 1'b1;
            r_tx_sof_n     <= 1'b1;
            r_tx_eof_n     <= 1'b1;
          end else begin
            if (w_event) begin
              r_pending <= 1'b1;
            end
            if (w_accept) begin
              if (r_state == ST_HDR) begin
                r_state    <= ST_DAT;
                r_tx_d     <= DATA_W'(r_snap);
                r_tx_sof_n <= 1'b1;
                r_tx_eof_n <= 1'b0;
              end else begin
                r_state        <= ST_IDLE;
                r_seq          <= r_seq + 1'b1;
                r_tx_d         <= '0;
                r_tx_rem       <= 1'b0;
                r_tx_src_rdy_n <= 1'b1;
                r_tx_sof_n     <= 1'b1;
                r_tx_eof_n     <= 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_state        = w_state;
  assign o_rise         = w_rise;
  assign o_fall         = w_fall;
  assign o_tx_d         = r_tx_d;
  assign o_tx_rem       = r_tx_rem;
  assign o_tx_src_rdy_n = r_tx_src_rdy_n;
  assign o_tx_sof_n     = r_tx_sof_n;
  assign o_tx_eof_n     = r_tx_eof_n;
  assign o_seq          = r_seq;

endmodule

`default_nettype wire

// File: tb/tb_input_status_framer.sv
// +--------------------------------------------------------------------------+
// | tb_input_status_framer : scoreboard bench for input_status_framer        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_input_status_framer;

  localparam int N_CH = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] in_raw;
  logic            channel_up;
  logic            dst_rdy_n;

  logic [N_CH-1:0] state_o, rise_o, fall_o;
  logic [15:0]     tx_d;
  logic            tx_rem, tx_src_rdy_n, tx_sof_n, tx_eof_n;
  logic [7:0]      seq_o;

  logic [N_CH-1:0] h_in_raw = '0;
  logic            h_channel_up = 1'b1;
  logic            h_dst_rdy_n = 1'b0;
  logic [N_CH-1:0] h_state, h_rise, h_fall;
  logic [15:0]     h_tx_d;
  logic            h_tx_rem, h_src_rdy_n, h_sof_n, h_eof_n;
  logic [7:0]      h_seq;

  typedef struct {
    logic [7:0]  seq;
    logic [15:0] data;
  } frame_t;

  frame_t sb_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     n_frames = 0;

  always #5 clk = ~clk;

  input_status_framer #(
    .N_CH(N_CH), .DATA_W(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .HEARTBEAT_CYCLES(0), .RESET_STATE('0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .i_in_raw(in_raw), .i_channel_up(channel_up),
    .o_state(state_o), .o_rise(rise_o), .o_fall(fall_o), .o_tx_d(tx_d),
    .o_tx_rem(tx_rem), .o_tx_src_rdy_n(tx_src_rdy_n), .o_tx_sof_n(tx_sof_n),
    .o_tx_eof_n(tx_eof_n), .i_tx_dst_rdy_n(dst_rdy_n), .o_seq(seq_o)
  );

  input_status_framer #(
    .N_CH(N_CH), .DATA_W(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .HEARTBEAT_CYCLES(20), .RESET_STATE('0)
  ) u_dut_hb (
    .clk(clk), .rst_n(rst_n), .i_in_raw(h_in_raw), .i_channel_up(h_channel_up),
    .o_state(h_state), .o_rise(h_rise), .o_fall(h_fall), .o_tx_d(h_tx_d),
    .o_tx_rem(h_tx_rem), .o_tx_src_rdy_n(h_src_rdy_n), .o_tx_sof_n(h_sof_n),
    .o_tx_eof_n(h_eof_n), .i_tx_dst_rdy_n(h_dst_rdy_n), .o_seq(h_seq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input logic [7:0] seq, input logic [15:0] data);
    frame_t f;
    f.seq  = seq;
    f.data = data;
    sb_q.push_back(f);
  endtask

  task automatic wait_frames(input int k, input int budget);
    int c = 0;
    while (n_frames < k && c < budget) begin
      tick();
      c++;
    end
    if (n_frames < k) check("timeout_frames", 32'(n_frames), 32'(k));
  endtask

  task automatic wait_src(input int budget);
    int c = 0;
    while (tx_src_rdy_n && c < budget) begin
      tick();
      c++;
    end
    if (tx_src_rdy_n) check("timeout_src_rdy", 32'(tx_src_rdy_n), 32'd0);
  endtask

  // Word acceptance is sampled mid-cycle, ahead of the edge that takes it.
  always @(negedge clk) begin
    if (rst_n && !tx_src_rdy_n && !dst_rdy_n) begin
      if (sb_q.size() == 0) begin
        check("unexpected_word", 32'(tx_d), 32'hFFFF_FFFF);
      end else if (!tx_sof_n) begin
        check("hdr_word", 32'(tx_d), {16'h0, 8'hA5, sb_q[0].seq});
        check("hdr_eof_n", 32'(tx_eof_n), 32'd1);
      end else begin
        check("dat_word", 32'(tx_d), 32'(sb_q[0].data));
        check("dat_rem", 32'(tx_rem), 32'd1);
        check("dat_eof_n", 32'(tx_eof_n), 32'd0);
        void'(sb_q.pop_front());
        n_frames++;
      end
    end
  end

  initial begin
    int lat;
    int ok;
    int bad;
    int c;
    int last;

    rst_n      = 1'b0;
    in_raw     = '0;
    channel_up = 1'b1;
    dst_rdy_n  = 1'b0;
    tick(3);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_rise_fall", 32'({rise_o, fall_o}), 32'd0);
    check("rst_tx_n", 32'({tx_src_rdy_n, tx_sof_n, tx_eof_n}), 32'b111);
    check("rst_tx_d_rem", 32'({tx_d, tx_rem}), 32'd0);
    check("rst_seq", 32'(seq_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Clean rising edge on channel 0
    in_raw = 5'b00001;
    push_frame(8'd0, 16'h0001);
    lat = 0;
    while (rise_o == '0 && lat < 20) begin
      tick();
      lat++;
    end
    check("rise_latency_ok", 32'(lat >= 5 && lat <= 7), 32'd1);
    check("rise_vector", 32'(rise_o), 32'b00001);
    check("state_after_rise", 32'(state_o), 32'b00001);
    tick();
    check("rise_one_cycle", 32'(rise_o), 32'd0);
    wait_frames(1, 40);
    check("seq_after_first", 32'(seq_o), 32'd1);

    // Glitch of 3 cycles must be filtered
    in_raw[2] = 1'b1;
    tick(3);
    in_raw[2] = 1'b0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (rise_o != '0 || fall_o != '0 || !tx_src_rdy_n) bad++;
      tick();
    end
    check("glitch_activity", 32'(bad), 32'd0);
    check("glitch_state", 32'(state_o), 32'b00001);

    // Header stalled by the sink for 10 cycles
    dst_rdy_n = 1'b1;
    in_raw    = 5'b00101;
    push_frame(8'd1, 16'h0005);
    wait_src(30);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_d[15:8] == 8'hA5 && !tx_sof_n && !tx_src_rdy_n) ok++;
      tick();
    end
    check("hdr_hold", 32'(ok), 32'd10);
    dst_rdy_n = 1'b0;
    wait_frames(2, 40);
    check("seq_after_stall", 32'(seq_o), 32'd2);

    // Changes during a stalled data word collapse into one follow-up frame
    dst_rdy_n = 1'b1;
    in_raw    = 5'b00000;
    push_frame(8'd2, 16'h0000);
    wait_src(30);
    dst_rdy_n = 1'b0;
    tick();
    dst_rdy_n = 1'b1;
    check("dat_stalled_eof", 32'(tx_eof_n), 32'd0);
    in_raw[1] = 1'b1;
    tick(10);
    in_raw[3] = 1'b1;
    tick(12);
    check("stall_snapshot", 32'(tx_d), 32'h0000);
    push_frame(8'd3, 16'h000A);
    dst_rdy_n = 1'b0;
    wait_frames(4, 60);
    tick(30);
    check("collapse_frames", 32'(n_frames), 32'd4);
    check("collapse_queue", 32'(sb_q.size()), 32'd0);
    check("seq_after_collapse", 32'(seq_o), 32'd4);

    // Link drop mid-header aborts; frame resent with the same sequence
    dst_rdy_n = 1'b1;
    in_raw    = 5'b01011;
    push_frame(8'd4, 16'h000B);
    wait_src(30);
    tick(2);
    channel_up = 1'b0;
    tick();
    check("abort_idle", 32'({tx_src_rdy_n, tx_sof_n, tx_eof_n}), 32'b111);
    tick(5);
    check("abort_still_idle", 32'(tx_src_rdy_n), 32'd1);
    check("abort_seq", 32'(seq_o), 32'd4);
    channel_up = 1'b1;
    dst_rdy_n  = 1'b0;
    wait_frames(5, 40);
    check("seq_after_resend", 32'(seq_o), 32'd5);

    // Heartbeat instance: frame period and sequence wrap
    last = int'(h_seq);
    c    = 0;
    while (int'(h_seq) == last && c < 100) begin
      tick();
      c++;
    end
    for (int k = 0; k < 3; k++) begin
      last = int'(h_seq);
      c    = 0;
      while (int'(h_seq) == last && c < 100) begin
        tick();
        c++;
      end
      check("hb_period_ok", 32'(c >= 20 && c <= 22), 32'd1);
    end
    check("hb_data", 32'(h_tx_d), 32'd0);
    c = 0;
    while (h_seq != 8'hFF && c < 8000) begin
      tick();
      c++;
    end
    check("hb_reach_ff", 32'(h_seq), 32'hFF);
    c = 0;
    while (h_seq == 8'hFF && c < 100) begin
      tick();
      c++;
    end
    check("hb_wrap", 32'(h_seq), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
